// File: rtl/riscv_pkg.sv
// Types and constants shared by the instruction-fetch path.
package riscv_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO of fetched {instruction, pc} entries with push/pop/flush.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t   mem_reg [DEPTH];
    logic [PW-1:0]  wr_ptr_reg;
    logic [PW-1:0]  rd_ptr_reg;
    logic [PW:0]    count_reg;
    logic           full;
    logic           push_ok;
    logic           pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (PW+1)'(DEPTH));
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;
    assign count   = count_reg;
    assign head    = mem_reg[rd_ptr_reg];

    // Storage carries no reset: an entry is only visible once count covers it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push_ok && (wr_ptr_reg == PW'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_reg <= count_reg + (PW+1)'(1);
            end else if (pop_ok && !push_ok) begin
                count_reg <= count_reg - (PW+1)'(1);
            end
        end
    end

    // Upstream credit accounting must keep these from ever happening.
    assert property (@(posedge clk) disable iff (rst) !(push && full && !flush));
    assert property (@(posedge clk) disable iff (rst) !(pop && empty && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, credit-based memory requests, prefetch FIFO, redirect flush.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_4_o
);

    localparam int PW = $clog2(DEPTH);

    fetch_state_t  state_reg;
    logic [31:0]   fetch_pc_reg;
    logic          inflight_reg;
    logic [31:0]   inflight_pc_reg;

    logic          run;
    logic          flush;
    logic [31:0]   target;
    logic          pop;
    logic          push;
    logic [PW+1:0] used;
    logic          credit;
    logic [PW:0]   count;
    logic          empty;
    fetch_entry_t  head;
    fetch_entry_t  push_data;
    logic          unused_bits;

    assign unused_bits = ^redirect_pc_i[1:0];

    assign run    = (state_reg == RUN);
    assign flush  = run & redirect_i;
    assign target = {redirect_pc_i[31:2], 2'b00};

    assign valid_o = ~empty & ~flush;
    assign pop     = valid_o & ready_i;

    // Entries buffered plus the one in flight, less the one leaving this cycle.
    assign used   = {1'b0, count} + (PW+2)'(inflight_reg) - (PW+2)'(pop);
    assign credit = (used < (PW+2)'(DEPTH));

    assign imem_req_o  = run & (redirect_i | credit);
    assign imem_addr_o = flush ? target : fetch_pc_reg;

    assign push           = inflight_reg & ~flush;
    assign push_data.inst = imem_rdata_i;
    assign push_data.pc   = inflight_pc_reg;

    assign inst_o = valid_o ? head.inst : NOP_INST;
    assign pc_o   = valid_o ? head.pc : 32'h0;
    assign pc_4_o = valid_o ? head.pc + 32'd4 : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= BOOT;
            fetch_pc_reg    <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
        end else begin
            case (state_reg)
                BOOT: begin
                    state_reg    <= RUN;
                    inflight_reg <= 1'b0;
                    if (redirect_i) begin
                        fetch_pc_reg <= target;
                    end
                end
                default: begin
                    inflight_reg <= imem_req_o;
                    if (imem_req_o) begin
                        fetch_pc_reg    <= imem_addr_o + 32'd4;
                        inflight_pc_reg <= imem_addr_o;
                    end
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .empty     (empty)
    );

endmodule
